// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - steps through a song held in an external synchronous ROM and feeds note_player
//
// Purpose:
//    Fetches {note, duration} entries of the selected song in order. Each
//    entry is presented to note_player with a one-cycle load_new_note pulse.
//    The sequencer then waits for done_with_note before fetching the next
//    entry. A duration of zero marks the end of a song, and so does finishing
//    the last index of the song.
//
// Configuration macro:
//    SONG_LOOP_EN - when defined, the end of a song restarts the same song
//                   from index 0. DONE is never entered, and song_done pulses
//                   for one cycle at each loop. When undefined, the
//                   sequencer parks in DONE until next_song or reset.
//
// Ports:
//    clk               in   1              system clock, rising edge
//    reset             in   1              asynchronous assert, active-low
//    play              in   1              level: 1 = run, 0 = pause
//    next_song         in   1              pulse: jump to start of next song
//    done_with_note    in   1              note_player finished current note
//    rom_addr          out  SONG_W+NOTE_W  {current_song, note_idx}
//    rom_data          in   12             {note[11:6], duration[5:0]}, 1 clk after addr
//    note_to_load      out  6              note for note_player
//    duration_to_load  out  6              duration (1/48 s beats) for note_player
//    load_new_note     out  1              pulse: note/duration valid this cycle
//    play_enable       out  1              high in LOAD and WAIT_NOTE only
//    song_done         out  1              current song has ended
//    current_song      out  SONG_W         selected song index

module song_sequencer #(
   parameter int SONG_W = 2,
   parameter int NOTE_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     play,
   input  logic                     next_song,
   input  logic                     done_with_note,
   output logic [SONG_W+NOTE_W-1:0] rom_addr,
   input  logic [11:0]              rom_data,
   output logic [5:0]               note_to_load,
   output logic [5:0]               duration_to_load,
   output logic                     load_new_note,
   output logic                     play_enable,
   output logic                     song_done,
   output logic [SONG_W-1:0]        current_song
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FETCH     = 3'd1;
   localparam logic [2:0] ST_WAIT_ROM  = 3'd2;
   localparam logic [2:0] ST_LOAD      = 3'd3;
   localparam logic [2:0] ST_WAIT_NOTE = 3'd4;
   localparam logic [2:0] ST_PAUSED    = 3'd5;
   localparam logic [2:0] ST_DONE      = 3'd6;

   localparam logic [NOTE_W-1:0] IDX_LAST = {NOTE_W{1'b1}};

   logic [2:0]        state;
   logic [2:0]        state_d;
   logic [NOTE_W-1:0] note_idx;
   logic [NOTE_W-1:0] note_idx_d;
   logic [SONG_W-1:0] song_d;
   logic              capture;
   logic              end_of_song;

   // The ROM is addressed straight from the registered song and index. The
   // index is already updated by the time FETCH is entered, so the data
   // returned during WAIT_ROM belongs to the entry being fetched.
   assign rom_addr = {current_song, note_idx};

   assign load_new_note = (state == ST_LOAD);
   assign play_enable   = (state == ST_LOAD) || (state == ST_WAIT_NOTE);

   always_comb begin
      state_d     = state;
      note_idx_d  = note_idx;
      song_d      = current_song;
      capture     = 1'b0;
      end_of_song = 1'b0;

      // next_song overrides everything else, including pause and
      // done_with_note arriving in the same cycle.
      if (next_song) begin
         song_d     = current_song + SONG_W'(1);
         note_idx_d = '0;
         state_d    = play ? ST_FETCH : ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (play) state_d = ST_FETCH;
            end
            ST_FETCH: begin
               state_d = play ? ST_WAIT_ROM : ST_PAUSED;
            end
            ST_WAIT_ROM: begin
               if (!play) begin
                  state_d = ST_PAUSED;
               end else begin
                  capture = 1'b1;
                  if (rom_data[5:0] == 6'd0) end_of_song = 1'b1;
                  else                       state_d     = ST_LOAD;
               end
            end
            ST_LOAD: begin
               state_d = play ? ST_WAIT_NOTE : ST_PAUSED;
            end
            ST_WAIT_NOTE: begin
               // Pausing wins over a simultaneous done_with_note: the index
               // is held and the same note is replayed when play returns.
               if (!play) begin
                  state_d = ST_PAUSED;
               end else if (done_with_note) begin
                  if (note_idx == IDX_LAST) begin
                     end_of_song = 1'b1;
                  end else begin
                     note_idx_d = note_idx + NOTE_W'(1);
                     state_d    = ST_FETCH;
                  end
               end
            end
            ST_PAUSED: begin
               if (play) state_d = ST_FETCH;
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

`ifdef SONG_LOOP_EN
         if (end_of_song) begin
            state_d    = ST_FETCH;
            note_idx_d = '0;
         end
`else
         if (end_of_song) begin
            state_d = ST_DONE;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= ST_IDLE;
         note_idx         <= '0;
         current_song     <= '0;
         note_to_load     <= 6'd0;
         duration_to_load <= 6'd0;
      end else begin
         state        <= state_d;
         note_idx     <= note_idx_d;
         current_song <= song_d;
         // The end-of-song marker is captured like any other entry, so the
         // note/duration registers always show the last word read.
         if (capture) begin
            note_to_load     <= rom_data[11:6];
            duration_to_load <= rom_data[5:0];
         end
      end
   end

`ifdef SONG_LOOP_EN
   // With looping the song never parks, so song_done marks each restart
   // with a single-cycle pulse in the FETCH cycle that begins the new pass.
   logic loop_pulse;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) loop_pulse <= 1'b0;
      else        loop_pulse <= end_of_song;
   end

   assign song_done = loop_pulse;
`else
   assign song_done = (state == ST_DONE);
`endif

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer

module tb_song_sequencer;

   localparam int SONG_W = 2;
   localparam int NOTE_W = 5;
   localparam int AW     = SONG_W + NOTE_W;

   logic          clk = 1'b0;
   logic          reset;
   logic          play;
   logic          next_song;
   logic          done_with_note;
   logic [AW-1:0] rom_addr;
   logic [11:0]   rom_data;
   logic [5:0]    note_to_load;
   logic [5:0]    duration_to_load;
   logic          load_new_note;
   logic          play_enable;
   logic          song_done;
   logic [SONG_W-1:0] current_song;

   logic [11:0] rom [0:(1<<AW)-1];

   logic [11:0] expq [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   bit          auto_en = 1'b0;
   int          auto_cnt = 0;

   song_sequencer #(.SONG_W(SONG_W), .NOTE_W(NOTE_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .play             (play),
      .next_song        (next_song),
      .done_with_note   (done_with_note),
      .rom_addr         (rom_addr),
      .rom_data         (rom_data),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .load_new_note    (load_new_note),
      .play_enable      (play_enable),
      .song_done        (song_done),
      .current_song     (current_song)
   );

   always #5 clk = ~clk;

   // Synchronous song ROM: data valid one clock after the address.
   always @(posedge clk) rom_data <= rom[rom_addr];

   // One cycle of the bench: sample outputs at the falling edge, pop the
   // scoreboard on each load pulse, and model note_player raising
   // done_with_note 4 cycles after each load when auto_en is set.
   task automatic tick();
      logic [11:0] exp;
      @(negedge clk);
      cyc++;
      if (load_new_note === 1'b1) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL load_unexpected: got note=%0d dur=%0d, none expected (cyc %0d)",
                     note_to_load, duration_to_load, cyc);
         end else begin
            exp = expq.pop_front();
            if ({note_to_load, duration_to_load} !== exp) begin
               errors++;
               $display("FAIL load_value: got note=%0d dur=%0d, expected note=%0d dur=%0d",
                        note_to_load, duration_to_load, exp[11:6], exp[5:0]);
            end
         end
      end
      if (auto_en) begin
         if (auto_cnt > 0) begin
            auto_cnt--;
            done_with_note = (auto_cnt == 0);
         end else begin
            done_with_note = 1'b0;
         end
         if (load_new_note === 1'b1) auto_cnt = 4;
      end else begin
         auto_cnt = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      play = 1'b0;
      next_song = 1'b0;
      done_with_note = 1'b0;
      auto_en = 1'b0;
      expq.delete();
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_load(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         tick();
         if (load_new_note === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_song_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         tick();
         if (song_done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      play = 1'b0;
      next_song = 1'b0;
      done_with_note = 1'b0;
      tick();
      checks++;
      if ({rom_addr, note_to_load, duration_to_load, load_new_note, play_enable,
           song_done, current_song} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: addr=%0d note=%0d dur=%0d load=%b pe=%b sd=%b song=%0d, expected all 0",
                  rom_addr, note_to_load, duration_to_load, load_new_note, play_enable,
                  song_done, current_song);
      end
      reset = 1'b1;
      // play=0 in IDLE: nothing happens.
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (rom_addr !== '0 || play_enable !== 1'b0 || song_done !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: addr=%0d pe=%b sd=%b, expected 0 0 0", rom_addr, play_enable, song_done);
      end
   endtask

   task automatic test_song0();
      bit ok;
      do_reset();
      expq.push_back({6'd5, 6'd3});
      expq.push_back({6'd9, 6'd2});
      auto_en = 1'b1;
      play = 1'b1;
      wait_song_done(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL song0_done_timeout: song_done=%b, expected 1 within 200 cycles", song_done);
      end
      checks++;
      if (rom_addr !== 7'd2) begin
         errors++;
         $display("FAIL song0_end_addr: got %0d, expected 2", rom_addr);
      end
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL song0_loads_missing: %0d loads outstanding, expected 0", expq.size());
      end
      checks++;
      if (duration_to_load !== 6'd0 || note_to_load !== 6'd7) begin
         errors++;
         $display("FAIL song0_marker_capture: note=%0d dur=%0d, expected note=7 dur=0",
                  note_to_load, duration_to_load);
      end
      // DONE holds, play=0 has no effect.
      play = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (song_done !== 1'b1 || rom_addr !== 7'd2 || play_enable !== 1'b0) begin
         errors++;
         $display("FAIL song0_done_hold: sd=%b addr=%0d pe=%b, expected 1 2 0", song_done, rom_addr, play_enable);
      end
   endtask

   task automatic test_pause();
      bit ok;
      do_reset();
      expq.push_back({6'd5, 6'd3});
      expq.push_back({6'd9, 6'd2});
      expq.push_back({6'd9, 6'd2});
      play = 1'b1;
      wait_load(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL pause_first_load_timeout: no load, expected one within 20 cycles");
      end
      // done_with_note during LOAD is ignored.
      done_with_note = 1'b1;
      tick();
      checks++;
      if (rom_addr !== 7'd0 || play_enable !== 1'b1) begin
         errors++;
         $display("FAIL done_in_load_ignored: addr=%0d pe=%b, expected 0 1", rom_addr, play_enable);
      end
      // Still high, now in WAIT_NOTE: this one advances.
      tick();
      done_with_note = 1'b0;
      checks++;
      if (rom_addr !== 7'd1 || load_new_note !== 1'b0) begin
         errors++;
         $display("FAIL advance_addr: addr=%0d load=%b, expected 1 0", rom_addr, load_new_note);
      end
      tick();
      tick();
      checks++;
      if (load_new_note !== 1'b1) begin
         errors++;
         $display("FAIL done_to_load_latency: load=%b 3 cycles after done, expected 1", load_new_note);
      end
      tick();
      play = 1'b0;
      tick();
      checks++;
      if (play_enable !== 1'b0 || rom_addr !== 7'd1) begin
         errors++;
         $display("FAIL paused_state: pe=%b addr=%0d, expected 0 1", play_enable, rom_addr);
      end
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (play_enable !== 1'b0 || rom_addr !== 7'd1 || load_new_note !== 1'b0) begin
         errors++;
         $display("FAIL paused_hold: pe=%b addr=%0d load=%b, expected 0 1 0", play_enable, rom_addr, load_new_note);
      end
      play = 1'b1;
      tick();
      checks++;
      if (rom_addr !== 7'd1 || play_enable !== 1'b0) begin
         errors++;
         $display("FAIL resume_fetch: addr=%0d pe=%b, expected 1 0", rom_addr, play_enable);
      end
      tick();
      tick();
      checks++;
      if (load_new_note !== 1'b1) begin
         errors++;
         $display("FAIL fetch_to_load_latency: load=%b 2 cycles after FETCH, expected 1", load_new_note);
      end
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL pause_loads_missing: %0d outstanding, expected 0", expq.size());
      end
   endtask

   task automatic test_next_song_priority();
      bit ok;
      do_reset();
      expq.push_back({6'd5, 6'd3});
      expq.push_back({6'd12, 6'd4});
      expq.push_back({6'd20, 6'd1});
      play = 1'b1;
      wait_load(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ns_first_load_timeout: no load, expected one within 20 cycles");
      end
      tick();
      next_song = 1'b1;
      done_with_note = 1'b1;
      tick();
      next_song = 1'b0;
      done_with_note = 1'b0;
      checks++;
      if (current_song !== 2'd1 || rom_addr !== 7'd32 || song_done !== 1'b0) begin
         errors++;
         $display("FAIL next_song_priority: song=%0d addr=%0d sd=%b, expected 1 32 0",
                  current_song, rom_addr, song_done);
      end
      auto_en = 1'b1;
      wait_song_done(200, ok);
      checks++;
      if (!ok || rom_addr !== 7'd34 || current_song !== 2'd1) begin
         errors++;
         $display("FAIL song1_end: done=%b addr=%0d song=%0d, expected 1 34 1", ok, rom_addr, current_song);
      end
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL song1_loads_missing: %0d outstanding, expected 0", expq.size());
      end
   endtask

   task automatic test_long_song();
      bit ok;
      for (int i = 0; i < 32; i++) expq.push_back(rom[64 + i]);
      play = 1'b1;
      next_song = 1'b1;
      tick();
      next_song = 1'b0;
      checks++;
      if (current_song !== 2'd2 || rom_addr !== 7'd64 || song_done !== 1'b0) begin
         errors++;
         $display("FAIL long_start: song=%0d addr=%0d sd=%b, expected 2 64 0", current_song, rom_addr, song_done);
      end
      wait_song_done(1000, ok);
      checks++;
      if (!ok || rom_addr !== 7'd95) begin
         errors++;
         $display("FAIL long_no_wrap: done=%b addr=%0d, expected 1 95", ok, rom_addr);
      end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (song_done !== 1'b1 || rom_addr !== 7'd95 || expq.size() != 0) begin
         errors++;
         $display("FAIL long_done_hold: sd=%b addr=%0d outstanding=%0d, expected 1 95 0",
                  song_done, rom_addr, expq.size());
      end
   endtask

   task automatic test_song_wrap();
      auto_en = 1'b0;
      done_with_note = 1'b0;
      play = 1'b0;
      next_song = 1'b1;
      tick();
      next_song = 1'b0;
      checks++;
      if (current_song !== 2'd3 || rom_addr !== 7'd96 || song_done !== 1'b0 || play_enable !== 1'b0) begin
         errors++;
         $display("FAIL song3_select: song=%0d addr=%0d sd=%b pe=%b, expected 3 96 0 0",
                  current_song, rom_addr, song_done, play_enable);
      end
      next_song = 1'b1;
      tick();
      next_song = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (current_song !== 2'd0 || rom_addr !== 7'd0 || load_new_note !== 1'b0) begin
         errors++;
         $display("FAIL song_wrap: song=%0d addr=%0d load=%b, expected 0 0 0", current_song, rom_addr, load_new_note);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      do_reset();
      expq.push_back({6'd5, 6'd3});
      play = 1'b1;
      wait_load(20, ok);
      tick();
      checks++;
      if (!ok || play_enable !== 1'b1) begin
         errors++;
         $display("FAIL ar_wait_note: loaded=%b pe=%b, expected 1 1", ok, play_enable);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({rom_addr, note_to_load, duration_to_load, load_new_note, play_enable,
           song_done, current_song} !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs: addr=%0d note=%0d dur=%0d load=%b pe=%b sd=%b song=%0d, expected all 0",
                  rom_addr, note_to_load, duration_to_load, load_new_note, play_enable,
                  song_done, current_song);
      end
      play = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (rom_addr !== 7'd0 || play_enable !== 1'b0 || load_new_note !== 1'b0) begin
         errors++;
         $display("FAIL after_async_reset: addr=%0d pe=%b load=%b, expected 0 0 0",
                  rom_addr, play_enable, load_new_note);
      end
   endtask

   initial begin
      reset = 1'b0;
      play = 1'b0;
      next_song = 1'b0;
      done_with_note = 1'b0;
      for (int i = 0; i < (1 << AW); i++) rom[i] = 12'd0;
      rom[0]  = {6'd5, 6'd3};
      rom[1]  = {6'd9, 6'd2};
      rom[2]  = {6'd7, 6'd0};
      rom[32] = {6'd12, 6'd4};
      rom[33] = {6'd20, 6'd1};
      rom[34] = {6'd3, 6'd0};
      for (int i = 0; i < 32; i++) rom[64 + i] = {6'((i + 10) % 64), 6'((i % 7) + 1)};
      rom[96] = {6'd33, 6'd6};

      test_reset();
      test_song0();
      test_pause();
      test_next_song_priority();
      test_long_song();
      test_song_wrap();
      test_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
